// File: rtl/prog_sequencer.sv
// Run-control sequencer for a single fetch PC driving a ROM of back-to-back
// programs. It holds the PC while the bench works on data memory, releases it
// on start, detects the halt instruction, counts RUN cycles per program, stops
// runaway programs with a watchdog and gates decoder/ALU branch requests.
module prog_sequencer #(
  parameter int            NUM_PROGS  = 3,
  parameter int            W          = 16,
  parameter logic [W-1:0]  MAX_CYCLES = {W{1'b1}}
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_halt,
  input  logic         i_br_rel,
  input  logic         i_br_abs,
  input  logic         i_br_taken,
  input  logic [W-1:0] i_br_target,
  input  logic [W-1:0] i_pc,
  output logic         o_pc_stall,
  output logic         o_jump_rel,
  output logic         o_jump_abs,
  output logic [W-1:0] o_target,
  output logic         o_done,
  output logic [1:0]   o_prog_id,
  output logic [W-1:0] o_start_pc,
  output logic [W-1:0] o_cycle_count,
  output logic         o_timeout,
  output logic         o_all_done
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_DONE     = 3'd2,
    ST_FINISHED = 3'd3,
    ST_TRAP     = 3'd4
  } state_t;

  localparam logic [W-1:0] LP_CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] LP_ONE      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] LP_WD_LIMIT = MAX_CYCLES - LP_ONE;
  localparam logic         LP_WD_EN    = (MAX_CYCLES != {W{1'b0}});
  localparam logic [1:0]   LP_LAST_ID  = 2'(NUM_PROGS - 1);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_run_cnt;
  logic [W-1:0] w_cnt_sat;
  logic [1:0]   r_prog_id;
  logic [W-1:0] r_start_pc;
  logic [W-1:0] r_cycle_count;
  logic         r_timeout;
  logic         r_all_done;
  logic         w_in_run;
  logic         w_is_last;
  logic         w_wd_hit;

  assign w_in_run  = (r_state == ST_RUN);
  assign w_is_last = (r_prog_id == LP_LAST_ID);
  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign w_cnt_sat = (r_run_cnt == LP_CNT_MAX) ? r_run_cnt : (r_run_cnt + LP_ONE);
  assign w_wd_hit  = LP_WD_EN && (r_run_cnt == LP_WD_LIMIT);

  // Next-state logic; halt outranks the watchdog in the same RUN cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          if (w_is_last) begin
            w_state_nxt = ST_FINISHED;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else if (w_wd_hit) begin
          w_state_nxt = ST_TRAP;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_FINISHED: w_state_nxt = ST_FINISHED;
      ST_TRAP:     w_state_nxt = ST_TRAP;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Combinational PC controls: PC runs only in RUN, halt suppresses any jump,
  // and a relative request wins over an absolute one.
  always_comb begin
    o_pc_stall = 1'b1;
    o_jump_rel = 1'b0;
    o_jump_abs = 1'b0;
    o_target   = i_br_target;
    o_done     = (r_state == ST_DONE) || (r_state == ST_FINISHED);
    if (w_in_run) begin
      o_pc_stall = 1'b0;
      o_jump_rel = i_br_rel & i_br_taken & ~i_halt;
      o_jump_abs = i_br_abs & i_br_taken & ~i_br_rel & ~i_halt;
    end else begin
      o_pc_stall = 1'b1;
      o_jump_rel = 1'b0;
      o_jump_abs = 1'b0;
    end
  end

  // State register plus registered status: counter, program id, start PC,
  // cycle count and the sticky timeout / all-done flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_run_cnt     <= {W{1'b0}};
      r_prog_id     <= 2'd0;
      r_start_pc    <= {W{1'b0}};
      r_cycle_count <= {W{1'b0}};
      r_timeout     <= 1'b0;
      r_all_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_run_cnt <= {W{1'b0}};
          end
        end
        ST_RUN: begin
          r_run_cnt <= w_cnt_sat;
          // Counter is cleared on RUN entry, so zero marks the first RUN cycle.
          if (r_run_cnt == {W{1'b0}}) begin
            r_start_pc <= i_pc;
          end
          if (i_halt) begin
            r_cycle_count <= w_cnt_sat;
          end
          if (w_state_nxt == ST_FINISHED) begin
            r_all_done <= 1'b1;
          end
          if (w_state_nxt == ST_TRAP) begin
            r_timeout <= 1'b1;
          end
        end
        ST_DONE: begin
          if (i_start) begin
            r_prog_id <= r_prog_id + 2'd1;
            r_run_cnt <= {W{1'b0}};
          end
        end
        default: begin
          r_run_cnt <= r_run_cnt;
        end
      endcase
    end
  end

  assign o_prog_id     = r_prog_id;
  assign o_start_pc    = r_start_pc;
  assign o_cycle_count = r_cycle_count;
  assign o_timeout     = r_timeout;
  assign o_all_done    = r_all_done;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: stimulus pushes hand-computed expected
// values, a negedge monitor pops and compares them against the DUT. A small
// PC model follows the DUT's stall/jump outputs like the real fetch PC would.
module tb_prog_sequencer;

  typedef struct {
    string       name;
    int          dut;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  localparam int S_STALL = 0, S_JREL = 1, S_JABS = 2, S_TGT = 3, S_DONE = 4,
                 S_PID = 5, S_SPC = 6, S_CCNT = 7, S_TMO = 8, S_ALLD = 9, S_PC = 10;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT stimulus / responses
  logic        reset = 1'b1, start = 1'b0, halt_man = 1'b0, halt_auto = 1'b1;
  logic        br_rel = 1'b0, br_abs = 1'b0, br_taken = 1'b0;
  logic [15:0] br_target = 16'd0;
  logic        halt;
  logic [15:0] pc = 16'd0;
  logic        pc_load = 1'b1;
  logic [15:0] pc_load_val = 16'd0;
  logic        pc_stall, jump_rel, jump_abs, done, timeout, all_done;
  logic [15:0] target, start_pc, cycle_count;
  logic [1:0]  prog_id;

  // watchdog DUT (MAX_CYCLES = 8) stimulus / responses
  logic        wd_reset = 1'b1, wd_start = 1'b0;
  logic        zero_b = 1'b0;
  logic [15:0] zero_w = 16'd0;
  logic [15:0] wd_pc = 16'd100;
  logic        wd_pc_stall, wd_jump_rel, wd_jump_abs, wd_done, wd_timeout, wd_all_done;
  logic [15:0] wd_target, wd_start_pc, wd_cycle_count;
  logic [1:0]  wd_prog_id;

  // ROM decoder for the straight-line programs: halts at 9, 13 and 19
  assign halt = halt_auto ? ((pc == 16'd9) || (pc == 16'd13) || (pc == 16'd19)) : halt_man;

  prog_sequencer #(.NUM_PROGS(3), .W(16), .MAX_CYCLES(16'hFFFF)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_halt(halt),
    .i_br_rel(br_rel), .i_br_abs(br_abs), .i_br_taken(br_taken),
    .i_br_target(br_target), .i_pc(pc),
    .o_pc_stall(pc_stall), .o_jump_rel(jump_rel), .o_jump_abs(jump_abs),
    .o_target(target), .o_done(done), .o_prog_id(prog_id),
    .o_start_pc(start_pc), .o_cycle_count(cycle_count),
    .o_timeout(timeout), .o_all_done(all_done)
  );

  prog_sequencer #(.NUM_PROGS(3), .W(16), .MAX_CYCLES(16'd8)) u_wd (
    .i_clk(clk), .i_reset(wd_reset), .i_start(wd_start), .i_halt(zero_b),
    .i_br_rel(zero_b), .i_br_abs(zero_b), .i_br_taken(zero_b),
    .i_br_target(zero_w), .i_pc(wd_pc),
    .o_pc_stall(wd_pc_stall), .o_jump_rel(wd_jump_rel), .o_jump_abs(wd_jump_abs),
    .o_target(wd_target), .o_done(wd_done), .o_prog_id(wd_prog_id),
    .o_start_pc(wd_start_pc), .o_cycle_count(wd_cycle_count),
    .o_timeout(wd_timeout), .o_all_done(wd_all_done)
  );

  // Fetch PC model: load wins, else advance/jump when not stalled
  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (!pc_stall) begin
      if (jump_rel)      pc <= pc + target;
      else if (jump_abs) pc <= target;
      else               pc <= pc + 16'd1;
    end
  end

  function automatic logic [15:0] pick(input int dut, input int sig);
    logic [15:0] v;
    v = 16'hDEAD;
    if (dut == 0) begin
      case (sig)
        S_STALL: v = {15'd0, pc_stall};
        S_JREL:  v = {15'd0, jump_rel};
        S_JABS:  v = {15'd0, jump_abs};
        S_TGT:   v = target;
        S_DONE:  v = {15'd0, done};
        S_PID:   v = {14'd0, prog_id};
        S_SPC:   v = start_pc;
        S_CCNT:  v = cycle_count;
        S_TMO:   v = {15'd0, timeout};
        S_ALLD:  v = {15'd0, all_done};
        S_PC:    v = pc;
        default: v = 16'hDEAD;
      endcase
    end else begin
      case (sig)
        S_STALL: v = {15'd0, wd_pc_stall};
        S_JREL:  v = {15'd0, wd_jump_rel};
        S_JABS:  v = {15'd0, wd_jump_abs};
        S_TGT:   v = wd_target;
        S_DONE:  v = {15'd0, wd_done};
        S_PID:   v = {14'd0, wd_prog_id};
        S_SPC:   v = wd_start_pc;
        S_CCNT:  v = wd_cycle_count;
        S_TMO:   v = {15'd0, wd_timeout};
        S_ALLD:  v = {15'd0, wd_all_done};
        default: v = 16'hDEAD;
      endcase
    end
    return v;
  endfunction

  // Monitor: every expectation queued during this cycle is checked at negedge
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = sb.pop_front();
      act = pick(e.dut, e.sig);
      checks = checks + 1;
      if (act !== e.exp) begin
        errors = errors + 1;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic expect_v(input string name, input int dut, input int sig, input logic [15:0] v);
    exp_t e;
    e.name = name; e.dut = dut; e.sig = sig; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---------------- reset state ----------------
    cyc();
    expect_v("rst_stall", 0, S_STALL, 16'd1);
    expect_v("rst_jrel",  0, S_JREL,  16'd0);
    expect_v("rst_jabs",  0, S_JABS,  16'd0);
    expect_v("rst_tgt",   0, S_TGT,   16'd0);
    expect_v("rst_done",  0, S_DONE,  16'd0);
    expect_v("rst_pid",   0, S_PID,   16'd0);
    expect_v("rst_spc",   0, S_SPC,   16'd0);
    expect_v("rst_ccnt",  0, S_CCNT,  16'd0);
    expect_v("rst_tmo",   0, S_TMO,   16'd0);
    expect_v("rst_alld",  0, S_ALLD,  16'd0);
    reset = 1'b0; pc_load = 1'b0;
    repeat (3) cyc();
    expect_v("idle_stall", 0, S_STALL, 16'd1);
    expect_v("idle_pc",    0, S_PC,    16'd0);

    // ---------------- program 0: 10 straight-line instructions ----------------
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      expect_v("p0_run_stall", 0, S_STALL, 16'd0);
      expect_v("p0_run_pc",    0, S_PC,    16'(i));
      cyc();
    end
    expect_v("p0_done",  0, S_DONE,  16'd1);
    expect_v("p0_stall", 0, S_STALL, 16'd1);
    expect_v("p0_pc",    0, S_PC,    16'd10);
    expect_v("p0_ccnt",  0, S_CCNT,  16'd10);
    expect_v("p0_spc",   0, S_SPC,   16'd0);
    expect_v("p0_pid",   0, S_PID,   16'd0);
    expect_v("p0_alld",  0, S_ALLD,  16'd0);
    cyc();
    expect_v("p0_pc_held", 0, S_PC, 16'd10);

    // ---------------- program 1: 4 cycles ----------------
    start = 1'b1; cyc(); start = 1'b0;
    expect_v("p1_pid",   0, S_PID,   16'd1);
    expect_v("p1_done0", 0, S_DONE,  16'd0);
    expect_v("p1_stall", 0, S_STALL, 16'd0);
    repeat (4) cyc();
    expect_v("p1_done", 0, S_DONE, 16'd1);
    expect_v("p1_ccnt", 0, S_CCNT, 16'd4);
    expect_v("p1_spc",  0, S_SPC,  16'd10);
    expect_v("p1_pc",   0, S_PC,   16'd14);

    // ---------------- program 2: 6 cycles, last program ----------------
    start = 1'b1; cyc(); start = 1'b0;
    expect_v("p2_pid", 0, S_PID, 16'd2);
    repeat (6) cyc();
    expect_v("p2_done", 0, S_DONE, 16'd1);
    expect_v("p2_alld", 0, S_ALLD, 16'd1);
    expect_v("p2_ccnt", 0, S_CCNT, 16'd6);
    expect_v("p2_spc",  0, S_SPC,  16'd14);
    expect_v("p2_pc",   0, S_PC,   16'd20);
    start = 1'b1; cyc(); cyc(); start = 1'b0;
    expect_v("fin_pc",    0, S_PC,    16'd20);
    expect_v("fin_stall", 0, S_STALL, 16'd1);
    expect_v("fin_alld",  0, S_ALLD,  16'd1);
    expect_v("fin_pid",   0, S_PID,   16'd2);

    // ---------------- branch gating ----------------
    halt_auto = 1'b0; reset = 1'b1; pc_load = 1'b1; pc_load_val = 16'd0;
    cyc();
    reset = 1'b0; pc_load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    repeat (7) cyc();
    expect_v("br_pc7", 0, S_PC, 16'd7);
    br_rel = 1'b1; br_taken = 1'b1; br_target = 16'hFFFD;
    expect_v("rel_jrel", 0, S_JREL, 16'd1);
    expect_v("rel_jabs", 0, S_JABS, 16'd0);
    expect_v("rel_tgt",  0, S_TGT,  16'hFFFD);
    cyc();
    expect_v("rel_pc4", 0, S_PC, 16'd4);
    br_rel = 1'b0; br_taken = 1'b0;
    repeat (3) cyc();
    br_rel = 1'b1; br_taken = 1'b0;
    expect_v("nt_pc7", 0, S_PC,   16'd7);
    expect_v("nt_jrel", 0, S_JREL, 16'd0);
    cyc();
    expect_v("nt_pc8", 0, S_PC, 16'd8);
    br_rel = 1'b1; br_abs = 1'b1; br_taken = 1'b1; br_target = 16'd20;
    expect_v("both_jrel", 0, S_JREL, 16'd1);
    expect_v("both_jabs", 0, S_JABS, 16'd0);
    cyc();
    expect_v("both_pc28", 0, S_PC, 16'd28);
    br_rel = 1'b0; br_abs = 1'b1; br_target = 16'd40;
    expect_v("abs_jabs", 0, S_JABS, 16'd1);
    cyc();
    expect_v("abs_pc40", 0, S_PC, 16'd40);
    halt_man = 1'b1; br_target = 16'd5;
    expect_v("hb_jabs", 0, S_JABS, 16'd0);
    expect_v("hb_jrel", 0, S_JREL, 16'd0);
    expect_v("hb_done", 0, S_DONE, 16'd0);
    cyc();
    halt_man = 1'b0; br_rel = 1'b1; br_abs = 1'b0; br_target = 16'h0033;
    expect_v("hb_pc41",  0, S_PC,   16'd41);
    expect_v("hb_done1", 0, S_DONE, 16'd1);
    expect_v("hb_ccnt",  0, S_CCNT, 16'd15);
    expect_v("dn_jrel",  0, S_JREL, 16'd0);
    expect_v("dn_tgt",   0, S_TGT,  16'h0033);
    cyc();
    br_rel = 1'b0; br_taken = 1'b0;

    // ---------------- reset in 3rd RUN cycle ----------------
    start = 1'b1; cyc(); start = 1'b0;
    expect_v("mr_pid", 0, S_PID, 16'd1);
    cyc(); cyc();
    expect_v("mr_pc43", 0, S_PC, 16'd43);
    reset = 1'b1; cyc();
    expect_v("mr_stall", 0, S_STALL, 16'd1);
    expect_v("mr_pid0",  0, S_PID,   16'd0);
    expect_v("mr_spc",   0, S_SPC,   16'd0);
    expect_v("mr_ccnt",  0, S_CCNT,  16'd0);
    expect_v("mr_done",  0, S_DONE,  16'd0);
    expect_v("mr_pc44",  0, S_PC,    16'd44);
    reset = 1'b0; cyc();
    expect_v("mr_pc_frz", 0, S_PC,    16'd44);
    expect_v("mr_idle",   0, S_STALL, 16'd1);
    start = 1'b1; cyc(); start = 1'b0; halt_man = 1'b1; cyc(); halt_man = 1'b0;
    expect_v("rr_ccnt", 0, S_CCNT, 16'd1);
    expect_v("rr_spc",  0, S_SPC,  16'd44);
    expect_v("rr_done", 0, S_DONE, 16'd1);

    // ---------------- watchdog, MAX_CYCLES = 8 ----------------
    wd_reset = 1'b0; cyc();
    expect_v("wd_idle_stall", 1, S_STALL, 16'd1);
    wd_start = 1'b1; cyc(); wd_start = 1'b0;
    expect_v("wd_run1_stall", 1, S_STALL, 16'd0);
    repeat (7) cyc();
    expect_v("wd_run8_stall", 1, S_STALL, 16'd0);
    expect_v("wd_run8_tmo",   1, S_TMO,   16'd0);
    cyc();
    expect_v("wd_tmo",   1, S_TMO,   16'd1);
    expect_v("wd_stall", 1, S_STALL, 16'd1);
    expect_v("wd_done",  1, S_DONE,  16'd0);
    expect_v("wd_spc",   1, S_SPC,   16'd100);
    expect_v("wd_alld",  1, S_ALLD,  16'd0);
    wd_start = 1'b1; cyc(); cyc(); wd_start = 1'b0;
    expect_v("wd_ign_tmo",   1, S_TMO,   16'd1);
    expect_v("wd_ign_stall", 1, S_STALL, 16'd1);
    expect_v("wd_ign_pid",   1, S_PID,   16'd0);
    expect_v("wd_ign_done",  1, S_DONE,  16'd0);
    wd_reset = 1'b1; cyc();
    expect_v("wd_rst_tmo",   1, S_TMO,   16'd0);
    expect_v("wd_rst_stall", 1, S_STALL, 16'd1);

    cyc();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
